vpu_result_drain: RTL and testbench
===================================

Name: vpu_result_drain

Overview:
- Downstream of the deload index counter: sequences the drain of one finished ROW_A x ROW_A accumulator tile.
- Generates the deload strobe that advances the counter and uses the returned (row, col) indices to select accumulator elements.
- Requantises each element (arithmetic shift plus signed saturation), buffers it in a small FIFO and emits it on a valid/ready stream with its linear output address.

Parameters:
- ROW_A, 4, tile dimension; must be a power of 2 so the counter returns to (0,0) after a full tile.
- ACC_W, 32, signed accumulator width per element.
- OUT_W, 16, signed output element width; OUT_W <= ACC_W.
- SHIFT, 0, arithmetic right shift applied before saturation; 0 <= SHIFT < ACC_W.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse: tile accumulators are final, begin drain
- acc_flat  in  ROW_A*ROW_A*ACC_W  accumulators; element i = a*ROW_A+w at bits [i*ACC_W +: ACC_W]
- count_deload_a  in  clog2(ROW_A)  current row index from the deload counter
- count_deload_w  in  clog2(ROW_A)  current column index from the deload counter
- deload  out  1  advance strobe to the deload counter
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  OUT_W  requantised element
- out_addr  out  2*clog2(ROW_A)  linear index a*ROW_A+w
- busy  out  1  high in DRAIN, FLUSH and DONE
- done  out  1  one-cycle pulse when the tile has been fully emitted

Behaviour:
- Reset: state IDLE, FIFO emptied, deload=0, out_valid=0, out_data=0, out_addr=0, busy=0, done=0. The deload counter shares the same reset, so indices restart at (0,0). Reset mid-drain abandons the tile and discards all FIFO contents.
- FSM states:
  - IDLE: start goes to DRAIN; start is ignored in every other state.
  - DRAIN: deload = fifo_not_full OR pop_this_cycle, where pop = out_valid & out_ready. Each cycle deload=1:
    - select acc_flat element at the current (pre-increment) indices;
    - requantise and push {addr, data} into the FIFO on the same edge the counter advances.
    - When deload=1 and indices == (ROW_A-1, ROW_A-1), go to FLUSH.
  - FLUSH: deload=0; when FIFO count == 0, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency, with out_ready held high and ROW_A=4:
  - start sampled in cycle 0; DRAIN cycles 1-16 with deload=1.
  - out_valid in cycles 2-17; FLUSH from cycle 17; done=1 in cycle 19.
- Requantise:
  - v = signed(acc) >>> SHIFT (floor toward -inf).
  - If v > 2^(OUT_W-1)-1, out = max; if v < -2^(OUT_W-1), out = min; otherwise out = v truncated to OUT_W bits.
- Stream rules:
  - out_data and out_addr are driven from the FIFO head and hold stable while out_valid & !out_ready.
  - out_valid never drops without a handshake.
  - Elements are emitted in strictly row-major order, addr 0..ROW_A^2-1.
- FIFO boundaries:
  - Full with no pop: deload=0 and the counter holds.
  - Full with a simultaneous pop: push is allowed and the count is unchanged.
  - Empty: out_valid=0.
  - The count never exceeds FIFO_DEPTH.

Test Plan:
- Basic drain: ROW_A=4, SHIFT=0, acc[i]=i*100, out_ready=1, start in cycle 0 -> 16 beats addr 0..15, data 0,100..1500; out_valid cycles 2-17; done only in cycle 19; deload high exactly 16 cycles.
- Backpressure: out_ready=0 for 10 cycles after start, then 1 -> deload drops after 4 pushes (FIFO_DEPTH=4); head holds addr 0 stable; all 16 beats are later emitted in order with no loss or duplication.
- Saturation: OUT_W=16, acc values 70000, -70000, 1234, -1 -> out 32767, -32768, 1234, -1.
- Shift: SHIFT=4, acc values 256 and -17 -> out 16 and -2.
- Reset mid-drain: assert reset in cycle 7 -> next cycle out_valid=0, busy=0, counter at (0,0); a new start then produces a full 16-beat tile from addr 0.
- Spurious start: pulse start again during DRAIN and during FLUSH -> ignored; exactly one done pulse and exactly 16 beats.

Source files
------------

// File: rtl/vpu_result_drain.sv
// Drains one finished ROW_A x ROW_A accumulator tile: strobes the external deload
// counter, requantises the selected element and streams it out through a small FIFO.
module vpu_result_drain #(
  parameter int ROW_A      = 4,
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ROW_A*ROW_A*ACC_W-1:0]  acc_flat,
  input  logic [$clog2(ROW_A)-1:0]      count_deload_a,
  input  logic [$clog2(ROW_A)-1:0]      count_deload_w,
  output logic                          deload,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              out_data,
  output logic [2*$clog2(ROW_A)-1:0]    out_addr,
  output logic                          busy,
  output logic                          done
);

  localparam int AW = $clog2(ROW_A);
  localparam int NE = ROW_A * ROW_A;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [2*AW-1:0]         idx;
  logic signed [ACC_W-1:0] acc_arr [NE];
  logic signed [ACC_W-1:0] acc_sel;
  logic signed [ACC_W-1:0] acc_shr;
  logic [OUT_W-1:0]        req_data;

  logic [OUT_W-1:0] data_mem_q [FIFO_DEPTH];
  logic [2*AW-1:0]  addr_mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push, pop, full, empty;

  // Element select at the counter's pre-increment indices, then requantise.
  always_comb begin
    for (int unsigned i = 0; i < NE; i++) begin
      acc_arr[i] = acc_flat[i*ACC_W +: ACC_W];
    end
  end

  assign idx     = {count_deload_a, count_deload_w};
  assign acc_sel = acc_arr[idx];
  assign acc_shr = acc_sel >>> SHIFT;

  always_comb begin
    if (acc_shr > SAT_MAX) begin
      req_data = SAT_MAX[OUT_W-1:0];
    end else if (acc_shr < SAT_MIN) begin
      req_data = SAT_MIN[OUT_W-1:0];
    end else begin
      req_data = acc_shr[OUT_W-1:0];
    end
  end

  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign empty     = (cnt_q == '0);
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign push      = deload;
  assign out_data  = empty ? '0 : data_mem_q[rd_q];
  assign out_addr  = empty ? '0 : addr_mem_q[rd_q];

  // A push into a full FIFO is only issued alongside a pop, so the count never overflows.
  always_comb begin
    wr_d  = push ? wr_q + PW'(1) : wr_q;
    rd_d  = pop  ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_q] <= req_data;
      addr_mem_q[wr_q] <= idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_DRAIN;
      S_DRAIN: if (deload && (&idx)) state_d = S_FLUSH;
      S_FLUSH: if (empty) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    deload = (state_q == S_DRAIN) && (!full || pop);
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_vpu_result_drain.sv
// Directed scoreboard bench for vpu_result_drain: two instances (SHIFT=0 and SHIFT=4)
// share stimulus, each with its own model of the deload index counter.
module tb_vpu_result_drain;

  logic              clk;
  logic              reset;
  logic              start;
  logic              out_ready;
  logic [511:0]      acc_flat;
  logic signed [31:0] acc [16];

  logic [1:0]  ca0, cw0, ca1, cw1;
  logic        deload0, out_valid0, busy0, done0;
  logic        deload1, out_valid1, busy1, done1;
  logic [15:0] out_data0, out_data1;
  logic [3:0]  out_addr0, out_addr1;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] d0;
    logic [15:0] d1;
  } exp_t;

  exp_t sb [$];
  int   checks   = 0;
  int   failures = 0;
  int   beats    = 0;

  vpu_result_drain #(.ROW_A(4), .ACC_W(32), .OUT_W(16), .SHIFT(0), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .reset(reset), .start(start), .acc_flat(acc_flat),
    .count_deload_a(ca0), .count_deload_w(cw0), .deload(deload0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_addr(out_addr0), .busy(busy0), .done(done0)
  );

  vpu_result_drain #(.ROW_A(4), .ACC_W(32), .OUT_W(16), .SHIFT(4), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .start(start), .acc_flat(acc_flat),
    .count_deload_a(ca1), .count_deload_w(cw1), .deload(deload1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_addr(out_addr1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 16; i++) acc_flat[i*32 +: 32] = acc[i];
  end

  // Row-major deload counters, reset together with the DUTs.
  always_ff @(posedge clk) begin
    if (reset) {ca0, cw0} <= '0;
    else if (deload0) {ca0, cw0} <= {ca0, cw0} + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) {ca1, cw1} <= '0;
    else if (deload1) {ca1, cw1} <= {ca1, cw1} + 4'd1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rq(input logic signed [31:0] a, input int sh);
    longint v;
    v = longint'(a) >>> sh;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  task automatic push_tile();
    for (int i = 0; i < 16; i++) begin
      exp_t e;
      e.addr = 4'(i);
      e.d0   = rq(acc[i], 0);
      e.d1   = rq(acc[i], 4);
      sb.push_back(e);
    end
  endtask

  // Output monitor: scoreboard pops on each handshake, plus hold-under-backpressure checks.
  initial begin
    logic        hold_v;
    logic [3:0]  h_addr;
    logic [15:0] h_data;
    exp_t        e;
    hold_v = 1'b0;
    h_addr = '0;
    h_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("hold_valid", out_valid0, 1);
          check("hold_addr", out_addr0, h_addr);
          check("hold_data", out_data0, h_data);
        end
        if (out_valid0 && out_ready) begin
          beats++;
          check("beat_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("beat_addr", out_addr0, e.addr);
            check("beat_data", out_data0, e.d0);
            check("beat_addr_sh", out_addr1, e.addr);
            check("beat_data_sh", out_data1, e.d1);
          end
        end
        hold_v = out_valid0 && !out_ready;
        h_addr = out_addr0;
        h_data = out_data0;
      end
    end
  end

  task automatic run_tile(input int n, input int sp1, input int sp2,
                          output int dones, output int dls, output int nbeats);
    int b0;
    b0    = beats;
    dones = 0;
    dls   = 0;
    push_tile();
    for (int c = 0; c < n; c++) begin
      start = (c == 0) || (c == sp1) || (c == sp2);
      @(negedge clk);
      if (done0) dones++;
      if (deload0) dls++;
      @(posedge clk);
      #1;
    end
    start  = 1'b0;
    nbeats = beats - b0;
  endtask

  initial begin
    int dn, dl, nb, b0;
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) acc[i] = '0;
    repeat (3) @(posedge clk);
    #1;

    @(negedge clk);
    check("rst_valid", out_valid0, 0);
    check("rst_data", out_data0, 0);
    check("rst_addr", out_addr0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_deload", deload0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic drain with cycle-exact timing.
    for (int i = 0; i < 16; i++) acc[i] = i * 100;
    push_tile();
    b0 = beats;
    dl = 0;
    start = 1'b1;
    for (int c = 0; c < 23; c++) begin
      @(negedge clk);
      check("basic_valid", out_valid0, (c >= 2) && (c <= 17));
      check("basic_deload", deload0, (c >= 1) && (c <= 16));
      check("basic_done", done0, c == 19);
      check("basic_busy", busy0, (c >= 1) && (c <= 19));
      if (deload0) dl++;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    check("basic_deload_count", dl, 16);
    check("basic_beats", beats - b0, 16);
    check("basic_sb_empty", sb.size(), 0);
    check("basic_ctr_a", ca0, 0);
    check("basic_ctr_w", cw0, 0);

    // Backpressure: consumer stalls for 10 cycles after start.
    for (int i = 0; i < 16; i++) acc[i] = i * 100 + 5;
    push_tile();
    b0 = beats;
    dn = 0;
    out_ready = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_deload", deload0, (c >= 1) && (c <= 4));
      if (c >= 2) begin
        check("bp_valid", out_valid0, 1);
        check("bp_head_addr", out_addr0, 0);
        check("bp_head_data", out_data0, 5);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done0) dn++;
      @(posedge clk);
      #1;
    end
    check("bp_dones", dn, 1);
    check("bp_beats", beats - b0, 16);
    check("bp_sb_empty", sb.size(), 0);

    // Saturation and shift boundaries.
    for (int i = 0; i < 16; i++) acc[i] = i * -37;
    acc[0]  = 70000;
    acc[1]  = -70000;
    acc[2]  = 1234;
    acc[3]  = -1;
    acc[4]  = 256;
    acc[5]  = -17;
    acc[6]  = 32'h7fff_ffff;
    acc[7]  = 32'h8000_0000;
    acc[8]  = 32767;
    acc[9]  = 32768;
    acc[10] = -32768;
    acc[11] = -32769;
    run_tile(30, -1, -1, dn, dl, nb);
    check("sat_dones", dn, 1);
    check("sat_beats", nb, 16);
    check("sat_sb_empty", sb.size(), 0);

    // Reset in cycle 7 of a drain abandons the tile.
    for (int i = 0; i < 16; i++) acc[i] = 3000 - i * 211;
    push_tile();
    start = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rmid_valid", out_valid0, 0);
    check("rmid_busy", busy0, 0);
    check("rmid_deload", deload0, 0);
    check("rmid_ctr_a", ca0, 0);
    check("rmid_ctr_w", cw0, 0);
    @(posedge clk);
    #1;
    run_tile(30, -1, -1, dn, dl, nb);
    check("rmid_dones", dn, 1);
    check("rmid_beats", nb, 16);
    check("rmid_sb_empty", sb.size(), 0);

    // Spurious start pulses during DRAIN and FLUSH.
    for (int i = 0; i < 16; i++) acc[i] = (i * 977) - 4000;
    run_tile(40, 5, 17, dn, dl, nb);
    check("spur_dones", dn, 1);
    check("spur_deloads", dl, 16);
    check("spur_beats", nb, 16);
    check("spur_sb_empty", sb.size(), 0);
    check("spur_busy_end", busy0, 0);
    check("end_ctr_a", ca0, 0);
    check("end_ctr_w", cw0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
